imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of sign_extender: packs a 32-bit signed immediate into the instruction bit fields selected by
//  ImmSrc (I/S/B/J), merging it with a base instruction word (opcode/rd/rs/funct).
//  2-stage valid/ready pipeline feeding the instruction-memory loader; tags each word with a running byte
//  address and flags immediates that do not fit the selected format.
// PARAMETERS
//  ADDR_W     32  width of out_addr / address counter
//  BASE_ADDR  0   byte address of first emitted word; must be a multiple of 4
//  ERRCNT_W   8   width of err_count (only meaningful with IMM_ERRCNT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       async active-low reset
//  clear      in   1       sync flush: drop pipeline, reload address counter
//  in_valid   in   1       input word valid
//  in_ready   out  1       encoder can accept
//  ImmSrc     in   2       00 I, 01 S, 10 B, 11 J
//  imm        in   32      signed immediate (byte offset for B/J)
//  base_inst  in   32      instruction; imm-field bits are ignored/overwritten
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       downstream accepts
//  out_inst   out  32      encoded instruction
//  out_addr   out  ADDR_W  byte address of out_inst
//  out_err    out  1       imm out of range / misaligned for its format
//  err_count  out  ERRCNT_W saturating count of emitted words with out_err=1
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, err_count=0, pipeline empty.
//  Handshake: transfer on valid&&ready each side; out_* stable while out_valid&&!out_ready; no combinational
//   path in_valid->out_valid. in_ready = !clear && (!s1_valid || s2_ready); s2_ready = !s2_valid || out_ready.
//  Latency 2 cycles accept->out_valid; throughput 1 word/cycle when out_ready held high.
//  S1 registers inputs; S2 holds encoded word + err. Bits outside the imm field pass from base_inst unchanged.
//  Encoding:  I: inst[31:20]=imm[11:0]
//             S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
//             B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]
//             J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]
//  Range (signed compare on full 32 bits): I,S in [-2048,2047]; B in [-4096,4094] and imm[0]=0;
//   J in [-1048576,1048574] and imm[0]=0. Violation -> out_err=1; word still emitted with truncated bits.
//  out_addr: holds address of current output; +4 after each output handshake; wraps modulo 2^ADDR_W.
//  clear: next edge empties S1/S2 (out_valid=0), out_addr=BASE_ADDR; input offered that cycle not accepted;
//   clear dominates a simultaneous output handshake (counter reloads, does not increment). err_count unaffected.
//  rst_n asserted mid-transfer: all state dropped immediately, values as at reset.
// CONFIGURATION
//  IMM_ERRCNT_EN defined: err_count increments on each output handshake with out_err=1, saturates at all-ones.
//  Not defined: no counter register; err_count tied to 0. out_err is always present.
// STRUCTURE
//  riscv_pkg: ImmSrc constants IMM_I/IMM_S/IMM_B/IMM_J, range limits per format, shared with sign_extender.
//  Sub-module imm_field_pack (combinational): {ImmSrc, imm, base_inst} -> {inst, err}; imm_encoder adds
//   the two pipeline registers, handshake, address counter, error counter.
// TESTING
//  1 I: imm=-1, base=0x00000013, ImmSrc=00 -> out_inst=0xFFF00013, err=0, addr=BASE_ADDR, 2 cycles after accept.
//  2 S/B/J: imm=0x7FC S, 0xFFE B (err: >4094? no, 4094 ok), 0x800 J -> match ISA golden; sign_extender
//    decodes I/S/J back to imm; ranges: imm=2048 I -> err=1, imm=3 B -> err=1, imm=-1048576 J -> err=0.
//  3 Backpressure: stream 8 words, out_ready toggles 1/0 -> no loss/dup, order kept, addr BASE+0..BASE+28.
//  4 Wrap: ADDR_W=4, BASE_ADDR=12 -> addrs 12,0,4,8.
//  5 clear with out_valid&&out_ready and in_valid high -> pipeline empty next cycle, addr=BASE_ADDR, input dropped.
//  6 rst_n low mid-stream -> outputs at reset values asynchronously; IMM_ERRCNT_EN: 300 err words, W=8 -> 255.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate definitions: ImmSrc encodings, per-format range limits and a range-check helper.
// Used by imm_encoder / imm_field_pack and shared with the sign_extender decode side.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_S_MIN = -2048;
  localparam int IMM_S_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  // True when imm is representable in the selected format (B/J also require an even offset).
  function automatic logic imm_fits(input imm_src_e src, input logic signed [31:0] imm);
    logic fits;
    fits = 1'b0;
    case (src)
      IMM_I: fits = (imm >= IMM_I_MIN) && (imm <= IMM_I_MAX);
      IMM_S: fits = (imm >= IMM_S_MIN) && (imm <= IMM_S_MAX);
      IMM_B: fits = (imm >= IMM_B_MIN) && (imm <= IMM_B_MAX) && !imm[0];
      IMM_J: fits = (imm >= IMM_J_MIN) && (imm <= IMM_J_MAX) && !imm[0];
      default: fits = 1'b0;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: scatters a signed immediate into the I/S/B/J bit fields of base_inst
// and flags immediates that are out of range or misaligned for the chosen format.
module imm_field_pack
  import riscv_pkg::*;
(
  input  logic [1:0]  i_imm_src,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_base_inst,
  output logic [31:0] o_inst,
  output logic        o_err
);

  imm_src_e w_src;
  assign w_src = imm_src_e'(i_imm_src);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_inst = i_base_inst;
    case (w_src)
      IMM_I: o_inst[31:20] = i_imm[11:0];
      IMM_S: begin
        o_inst[31:25] = i_imm[11:5];
        o_inst[11:7]  = i_imm[4:0];
      end
      IMM_B: begin
        o_inst[31]    = i_imm[12];
        o_inst[30:25] = i_imm[10:5];
        o_inst[11:8]  = i_imm[4:1];
        o_inst[7]     = i_imm[11];
      end
      IMM_J: begin
        o_inst[31]    = i_imm[20];
        o_inst[30:21] = i_imm[10:1];
        o_inst[20]    = i_imm[11];
        o_inst[19:12] = i_imm[19:12];
      end
      default: o_inst = i_base_inst;
    endcase
  end

  assign o_err = !imm_fits(w_src, $signed(i_imm));

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with running byte address and out-of-range flag.
// Optional saturating error counter enabled by defining IMM_ERRCNT_EN.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          ImmSrc,
  input  logic [31:0]         imm,
  input  logic [31:0]         base_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic              r_s1_valid;
  logic [1:0]        r_s1_src;
  logic [31:0]       r_s1_imm;
  logic [31:0]       r_s1_base;
  logic              r_s2_valid;
  enc_word_t         r_s2_word;
  logic [ADDR_W-1:0] r_addr;

  logic              w_s2_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  enc_word_t         w_pack;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !clear && (!r_s1_valid || w_s2_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  imm_field_pack u_pack (
    .i_imm_src   (r_s1_src),
    .i_imm       (r_s1_imm),
    .i_base_inst (r_s1_base),
    .o_inst      (w_pack.inst),
    .o_err       (w_pack.err)
  );

  // NOTE: payload registers carry no reset; only the valid bits decide whether they are meaningful.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_src  <= ImmSrc;
      r_s1_imm  <= imm;
      r_s1_base <= base_inst;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_ready) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 reloads whenever it is free or draining; it holds still under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
    end else if (clear) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_word <= w_pack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BASE_ADDR;
    end else if (clear) begin
      r_addr <= BASE_ADDR;
    end else if (w_out_fire) begin
      r_addr <= r_addr + ADDR_W'(4);
    end
  end

`ifdef IMM_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_count;

  // Counts words the consumer actually took with out_err set; a concurrent clear does not undo that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_out_fire && r_s2_word.err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_word.inst;
  assign out_err   = r_s2_word.err;
  assign out_addr  = r_addr;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed ISA vectors, random traffic against an arithmetic
// reference model, backpressure, address wrap, clear, async reset and (IMM_ERRCNT_EN) error counting.
module tb_imm_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [1:0]  ImmSrc;
  logic [31:0] imm;
  logic [31:0] base_inst;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst, out_addr;
  logic [7:0]  err_count;

  logic        in_ready_w, out_valid_w, out_err_w;
  logic [31:0] out_inst_w;
  logic [3:0]  out_addr_w;
  logic [7:0]  err_count_w;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .ERRCNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .imm(imm), .base_inst(base_inst), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  // Narrow-address instance sharing the same stimulus, used to observe counter wrap.
  imm_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .ERRCNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
    .ImmSrc(ImmSrc), .imm(imm), .base_inst(base_inst), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_inst(out_inst_w), .out_addr(out_addr_w), .out_err(out_err_w),
    .err_count(err_count_w)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   n_out = 0;
  int   n_total = 0;
  int   model_errcnt = 0;
  logic hold_pend = 1'b0;
  logic [31:0] hold_inst, hold_addr;
  logic hold_err;
  logic last_obs_valid, last_accept;

  // Reference encoder written from the field tables with masks and shifts.
  function automatic void model_encode(input logic [1:0] src, input logic [31:0] v,
                                       input logic [31:0] b, output logic [31:0] inst,
                                       output logic err);
    longint s;
    longint lo, hi;
    logic even_only;
    logic [31:0] mask, field;
    s = longint'($signed(v));
    case (src)
      2'd0: begin
        lo = -2048; hi = 2047; even_only = 1'b0; mask = 32'hFFF0_0000;
        field = (v & 32'hFFF) << 20;
      end
      2'd1: begin
        lo = -2048; hi = 2047; even_only = 1'b0; mask = 32'hFE00_0F80;
        field = (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      end
      2'd2: begin
        lo = -4096; hi = 4094; even_only = 1'b1; mask = 32'hFE00_0F80;
        field = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) |
                (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
      end
      default: begin
        lo = -1048576; hi = 1048574; even_only = 1'b1; mask = 32'hFFFF_F000;
        field = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
                (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
      end
    endcase
    err  = (s < lo) || (s > hi) || (even_only && ((v & 32'h1) != 0));
    inst = (b & ~mask) | field;
  endfunction

  // sign_extender-style decode, used to confirm in-range words round-trip to the original imm.
  function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] inst);
    logic [31:0] r;
    case (src)
      2'd0: r = 32'($signed(inst) >>> 20);
      2'd1: r = 32'(($signed(inst) >>> 25) << 5) | ((inst >> 7) & 32'h1F);
      2'd2: r = ((inst >> 31) != 0 ? 32'hFFFF_F000 : 32'h0) | (((inst >> 7) & 32'h1) << 11) |
                (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      default: r = ((inst >> 31) != 0 ? 32'hFFF0_0000 : 32'h0) | (((inst >> 12) & 32'hFF) << 12) |
                   (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_imm();
    int bnd[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                    -1048576, 1048574, 1048575, 1048576};
    int x;
    case ($urandom_range(0, 3))
      0: x = int'($urandom());
      1: x = int'($urandom_range(0, 4095)) - 2048;
      2: x = bnd[$urandom_range(0, 11)];
      default: x = int'($urandom_range(0, 2097151)) - 1048576;
    endcase
    return 32'(x);
  endfunction

  // One clock of stimulus plus scoreboard bookkeeping, sampled 1 time unit after the falling edge.
  task automatic cycle(input logic iv, input logic [1:0] src, input logic [31:0] v,
                       input logic [31:0] b, input logic ordy, input logic clr,
                       input logic use_gold, input logic [31:0] g_inst, input logic g_err);
    exp_t e;
    logic [31:0] ei, ea, dec;
    logic ee;
    logic [3:0] ew;
    @(negedge clk);
    in_valid = iv; ImmSrc = src; imm = v; base_inst = b; out_ready = ordy; clear = clr;
    #1;
    last_obs_valid = out_valid;
    last_accept    = iv && in_ready;
    checks++;
    if (err_count !== 8'(model_errcnt)) begin
      errors++;
      $display("FAIL err_count: got %0d expected %0d", err_count, model_errcnt);
    end
    if (hold_pend) begin
      checks++;
      if (out_valid !== 1'b1 || out_inst !== hold_inst || out_err !== hold_err ||
          out_addr !== hold_addr) begin
        errors++;
        $display("FAIL stall_stable: got v=%b inst=%h err=%b addr=%h expected v=1 inst=%h err=%b addr=%h",
                 out_valid, out_inst, out_err, out_addr, hold_inst, hold_err, hold_addr);
      end
    end
    hold_pend = out_valid && !ordy && !clr;
    hold_inst = out_inst; hold_err = out_err; hold_addr = out_addr;
    if (clr) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_during_clear: got %b expected 0", in_ready);
      end
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_output: got inst=%h expected no word", out_inst);
      end else begin
        e  = q.pop_front();
        ea = BASE + 32'(n_out) * 32'd4;
        ew = 4'(12 + 4 * n_out);
        checks++;
        if (out_inst !== e.inst || out_err !== e.err) begin
          errors++;
          $display("FAIL word: got inst=%h err=%b expected inst=%h err=%b",
                   out_inst, out_err, e.inst, e.err);
        end
        checks++;
        if (out_addr !== ea || out_addr_w !== ew) begin
          errors++;
          $display("FAIL addr: got %h/%0d expected %h/%0d", out_addr, out_addr_w, ea, ew);
        end
        if (!e.err) begin
          dec = decode(e.src, out_inst);
          checks++;
          if (dec !== e.imm) begin
            errors++;
            $display("FAIL decode: got %h expected %h", dec, e.imm);
          end
        end
`ifdef IMM_ERRCNT_EN
        if (e.err && model_errcnt < 255) model_errcnt++;
`endif
        n_out++;
        n_total++;
      end
    end
    if (clr) begin
      q.delete();
      n_out = 0;
    end else if (iv && in_ready) begin
      if (use_gold) begin
        ei = g_inst; ee = g_err;
      end else begin
        model_encode(src, v, b, ei, ee);
      end
      e.inst = ei; e.err = ee; e.imm = v; e.src = src;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'd0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() > 0 && budget < 200) begin
      idle(1'b1);
      budget++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", q.size());
      q.delete();
    end
    idle(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = 2'd0; imm = '0; base_inst = '0;
    q.delete(); n_out = 0; model_errcnt = 0; hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_addr !== BASE ||
        err_count !== 8'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b inst=%h err=%b addr=%h cnt=%0d rdy=%b expected 0 0 0 %h 0 1",
               out_valid, out_inst, out_err, out_addr, err_count, in_ready, BASE);
    end
    checks++;
    if (out_valid_w !== 1'b0 || out_inst_w !== 32'h0 || out_err_w !== 1'b0 ||
        out_addr_w !== 4'd12 || err_count_w !== 8'h0 || in_ready_w !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_wrap: got v=%b inst=%h err=%b addr=%0d cnt=%0d rdy=%b expected 0 0 0 12 0 1",
               out_valid_w, out_inst_w, out_err_w, out_addr_w, err_count_w, in_ready_w);
    end
    do_reset();
  endtask

  task automatic test_latency();
    cycle(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 32'hFFF0_0013, 1'b0);
    checks++;
    if (last_accept !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: got %b expected 1", last_accept);
    end
    idle(1'b1);
    checks++;
    if (last_obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid=%b expected 0", last_obs_valid);
    end
    idle(1'b1);
    checks++;
    if (last_obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_2cyc: got out_valid=%b expected 1", last_obs_valid);
    end
    drain();
  endtask

  task automatic test_directed();
    logic [1:0]  d_src[7]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    logic [31:0] d_imm[7]  = '{32'hFFFF_FFFF, 32'h0000_07FC, 32'h0000_0FFE, 32'h0000_0800,
                               32'h0000_0800, 32'h0000_0003, 32'hFFF0_0000};
    logic [31:0] d_base[7] = '{32'h0000_0013, 32'h0000_2023, 32'h0000_0063, 32'h0000_006F,
                               32'h0000_0013, 32'h0000_0063, 32'h0000_006F};
    logic [31:0] d_inst[7] = '{32'hFFF0_0013, 32'h7E00_2E23, 32'h7E00_0FE3, 32'h0010_006F,
                               32'h8000_0013, 32'h0000_0163, 32'h8000_006F};
    logic        d_err[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int i = 0;
    int budget = 0;
    while (i < 7 && budget < 100) begin
      cycle(1'b1, d_src[i], d_imm[i], d_base[i], 1'b1, 1'b0, 1'b1, d_inst[i], d_err[i]);
      if (last_accept) i++;
      budget++;
    end
    drain();
  endtask

  task automatic test_random();
    int sent = 0;
    int budget = 0;
    logic iv;
    logic [1:0] src;
    while (sent < 200 && budget < 2000) begin
      iv  = ($urandom_range(0, 3) != 0);
      src = 2'($urandom_range(0, 3));
      cycle(iv, src, rand_imm(), $urandom(), ($urandom_range(0, 2) != 0), 1'b0, 1'b0, 32'h0, 1'b0);
      if (last_accept) sent++;
      budget++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int budget = 0;
    int start;
    logic ordy = 1'b1;
    do_reset();
    start = n_total;
    while ((sent < 8 || q.size() > 0) && budget < 100) begin
      cycle(sent < 8, 2'($urandom_range(0, 3)), rand_imm(), $urandom(), ordy,
            1'b0, 1'b0, 32'h0, 1'b0);
      if (last_accept) sent++;
      ordy = !ordy;
      budget++;
    end
    drain();
    checks++;
    if (n_total - start !== 8) begin
      errors++;
      $display("FAIL backpressure_count: got %0d words expected 8", n_total - start);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd0, 32'(i + 1), 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    idle(1'b1);
    cycle(1'b1, 2'd0, 32'd77, 32'h0000_0013, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    checks++;
    if (last_obs_valid !== 1'b0 || out_addr !== BASE || out_addr_w !== 4'd12) begin
      errors++;
      $display("FAIL clear_flush: got v=%b addr=%h/%0d expected v=0 addr=%h/12",
               last_obs_valid, out_addr, out_addr_w, BASE);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    cycle(1'b1, 2'd1, 32'd100, 32'h0000_2023, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd3, 32'h0000_1000 + 32'(2 * i), 32'h0000_006F, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_addr !== BASE ||
        err_count !== 8'h0 || out_addr_w !== 4'd12) begin
      errors++;
      $display("FAIL async_reset: got v=%b inst=%h err=%b addr=%h cnt=%0d expected 0 0 0 %h 0",
               out_valid, out_inst, out_err, out_addr, err_count, BASE);
    end
    q.delete(); n_out = 0; model_errcnt = 0; hold_pend = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'd0, 32'd5, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_errcnt();
    int sent = 0;
    int budget = 0;
    logic [7:0] exp_cnt;
    do_reset();
    while (sent < 300 && budget < 1000) begin
      cycle(1'b1, 2'd0, 32'd4096, $urandom(), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (last_accept) sent++;
      budget++;
    end
    drain();
`ifdef IMM_ERRCNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    checks++;
    if (err_count !== exp_cnt) begin
      errors++;
      $display("FAIL errcnt_saturate: got %0d expected %0d", err_count, exp_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = 2'd0; imm = '0; base_inst = '0;
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_errcnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
